adder_subtractor: RTL and testbench
===================================

Name: adder_subtractor

Overview:
- Parameterised two's-complement adder/subtractor with registered outputs.
- `sel=0` adds `a+b`; `sel=1` subtracts `a-b`, computed as `a + ~b + 1`.
- Used as a datapath arithmetic primitive.
- Single clock domain; results appear one cycle after inputs are sampled.

Parameters:
- bit_len, default 8, operand and result width in bits; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  bit_len  operand A, unsigned or two's complement.
- b  input  bit_len  operand B.
- sel  input  1  operation select: 0 = add, 1 = subtract.
- sum  output  bit_len  registered result, low bit_len bits.
- c_out  output  1  registered carry out of the MSB; for subtract it is the inverted borrow.

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Ports are named clk and rst_n.

Behaviour:
- Reset: when rst_n goes low, sum and c_out are forced to 0 immediately, independent of clk. They stay 0 while rst_n is low.
- Release: the first capture occurs on the first rising clk edge with rst_n high.
- Datapath (combinational):
  - b_eff = b XOR {bit_len{sel}}.
  - carry_in = sel.
  - Result is a bit_len-stage ripple-carry chain computing a + b_eff + carry_in.
  - Internal width is bit_len+1; the MSB carry becomes c_out.
- Registers: on each rising clk edge with rst_n high, sum <= chain result and c_out <= final carry.
- Latency and throughput:
  - Latency is exactly 1 cycle from the input sampling edge.
  - Throughput is 1 operation per cycle.
  - No enable and no handshake; inputs are sampled every edge.
- Add wrap-around: a+b ≥ 2^bit_len gives sum = (a+b) mod 2^bit_len with c_out=1; otherwise c_out=0.
- Subtract:
  - a ≥ b (unsigned): c_out=1, sum=a-b.
  - a < b: c_out=0 (borrow), sum = (a-b) mod 2^bit_len, i.e. the two's-complement negative.
  - a == b: sum=0, c_out=1.
  - b=0: sum=a, c_out=1, because ~0+1 carries out.
- Signed overflow is not reported; users derive it externally.
- sel changing on the same edge as a/b: the new sel applies to the new operands. No mixing across cycles.
- Reset mid-operation: an in-flight result is discarded. After rst_n rises, sum and c_out stay 0 until the next clk edge.
- No X propagation from reset: every register has a defined reset value.

Decomposition:
- Shared package: opcode constants SEL_ADD=1'b0 and SEL_SUB=1'b1; no typedefs required.
- One sub-module, full_adder:
  - Inputs x, y, cin; outputs s, cout.
  - s = x^y^cin; cout = majority(x,y,cin).
  - Instantiated bit_len times via generate to form the ripple chain.
- Top level holds the XOR conditioning, carry-in injection and output registers.

Test Plan (bit_len=8; check one cycle after the driving edge):
- Reset: assert rst_n=0 asynchronously mid-cycle with a=8, b=5 -> sum=0, c_out=0 immediately and held until the first edge after release.
- Add: a=8, b=5, sel=0 -> sum=13, c_out=0. Then a=10, b=6, sel=0 -> sum=16, c_out=0.
- Add wrap: a=200, b=100, sel=0 -> sum=44, c_out=1. Also a=255, b=1 -> sum=0, c_out=1.
- Subtract with borrow: a=5, b=10, sel=1 -> sum=251, c_out=0.
- Subtract without borrow: a=15, b=6, sel=1 -> sum=9, c_out=1. Also a=7, b=7 -> sum=0, c_out=1; a=0, b=0 -> sum=0, c_out=1.
- Back-to-back toggling:
  - Drive sel and operands alternating every cycle: (10,6,add) then (5,10,sub) then (15,6,sub).
  - Required outputs, one per cycle: 16/0, 251/0, 9/1.
  - Confirms 1-cycle latency and no cross-cycle mixing.
- Random check: randomised bit_len=8 and bit_len=1 runs against the reference model {c_out,sum} = a + (sel ? ~b : b) + sel.

Source files
------------

// File: rtl/adder_subtractor_pkg.sv
// adder_subtractor_pkg: opcode constants shared by the adder/subtractor slice
package adder_subtractor_pkg;
    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;
endpackage

// File: rtl/adder_subtractor_full_adder.sv
// full_adder: one-bit stage of the ripple-carry chain
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);
endmodule

// File: rtl/adder_subtractor.sv
// adder_subtractor: registered two's-complement add/subtract over a ripple-carry chain
module adder_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int bit_len = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [bit_len-1:0] a,
    input  logic [bit_len-1:0] b,
    input  logic               sel,
    output logic [bit_len-1:0] sum,
    output logic               c_out
);
    logic               sub;
    logic [bit_len-1:0] b_eff;
    logic [bit_len-1:0] s;
    logic [bit_len:0]   carry;

    assign sub      = (sel == SEL_SUB);
    assign b_eff    = b ^ {bit_len{sub}};
    assign carry[0] = sub;

    genvar i;
    generate
        for (i = 0; i < bit_len; i++) begin : g_fa
            full_adder u_fa (
                .x   (a[i]),
                .y   (b_eff[i]),
                .cin (carry[i]),
                .s   (s[i]),
                .cout(carry[i+1])
            );
        end
    endgenerate

    // capture the chain result every edge; reset clears it immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            sum   <= s;
            c_out <= carry[bit_len];
        end
    end
endmodule

// File: tb/tb_adder_subtractor.sv
// tb_adder_subtractor: randomized and directed check of 8-bit and 1-bit instances
module tb_adder_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       a1 = 1'b0, b1 = 1'b0, s1, c8, c1;
    int         total = 0;
    int         bad = 0;
    int         exp8, exp1;

    always #5 clk = ~clk;

    adder_subtractor #(.bit_len(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel), .sum(s8), .c_out(c8)
    );
    adder_subtractor #(.bit_len(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel), .sum(s1), .c_out(c1)
    );

    function automatic int ref_model(input int n, input int av, input int bv, input logic s);
        int m;
        m = 1 << n;
        if (s) return ((av >= bv) ? m : 0) + ((av - bv + m) % m);
        return av + bv;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input string tag, input int av, input int bv, input logic s);
        @(negedge clk);
        a8 = av[7:0];
        b8 = bv[7:0];
        sel = s;
        a1 = 1'($urandom);
        b1 = 1'($urandom);
        exp8 = ref_model(8, av, bv, s);
        exp1 = ref_model(1, int'(a1), int'(b1), s);
        @(posedge clk);
        #1;
        check({tag, "_w8"}, int'({c8, s8}), exp8);
        check({tag, "_w1"}, int'({c1, s1}), exp1);
    endtask

    initial begin
        #1;
        check("por_w8", int'({c8, s8}), 0);
        check("por_w1", int'({c1, s1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive("add_8_5", 8, 5, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", int'({c8, s8}), 0);
        @(posedge clk);
        #1;
        check("rst_hold", int'({c8, s8}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release", int'({c8, s8}), 0);
        @(posedge clk);
        #1;
        check("first_capture", int'({c8, s8}), 13);
        drive("add_10_6", 10, 6, 1'b0);
        check("add_10_6_lit", int'({c8, s8}), 16);
        drive("wrap_200_100", 200, 100, 1'b0);
        check("wrap_lit", int'({c8, s8}), 256 + 44);
        drive("wrap_255_1", 255, 1, 1'b0);
        drive("sub_5_10", 5, 10, 1'b1);
        check("borrow_lit", int'({c8, s8}), 251);
        drive("sub_15_6", 15, 6, 1'b1);
        drive("sub_7_7", 7, 7, 1'b1);
        drive("sub_0_0", 0, 0, 1'b1);
        drive("sub_b0", 77, 0, 1'b1);
        drive("b2b_add", 10, 6, 1'b0);
        check("b2b_1", int'({c8, s8}), 16);
        drive("b2b_sub", 5, 10, 1'b1);
        check("b2b_2", int'({c8, s8}), 251);
        drive("b2b_sub2", 15, 6, 1'b1);
        check("b2b_3", int'({c8, s8}), 256 + 9);
        for (int k = 0; k < 300; k++)
            drive("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
